// File: rtl/joy_pkg.sv
// rtl/joy_pkg.sv - shared constants and types for the multi-port NES pad interface
package joy_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int          JOY_MAX_BUTTONS = 16;
  localparam logic [15:0] JOY_BASE_ADDR   = 16'h4016;
  localparam logic        JOY_READ_FILL   = 1'b1;

  typedef struct packed {
    logic       en;
    logic [7:0] data;
  } joy_rd_t;

endpackage

// File: rtl/joy_multi_if.sv
// rtl/joy_multi_if.sv - CPU bus bundle between the CPU side and the pad interface
interface joy_multi_if;
  logic        cpu_read_in;
  logic        cpu_write_in;
  logic [15:0] cpu_address_in;
  logic [7:0]  cpu_data_in;
  logic        cpu_data_en_out;
  logic [7:0]  cpu_data_out;

  modport master (
    output cpu_read_in, cpu_write_in, cpu_address_in, cpu_data_in,
    input  cpu_data_en_out, cpu_data_out
  );

  modport slave (
    input  cpu_read_in, cpu_write_in, cpu_address_in, cpu_data_in,
    output cpu_data_en_out, cpu_data_out
  );
endinterface

// File: rtl/joy_port.sv
// rtl/joy_port.sv - one pad: button synchroniser, serial shift register, saturating bit counter
module joy_port
  import joy_pkg::*;
#(
  parameter int BUTTONS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BUTTONS-1:0] buttons_n,
  input  logic [BUTTONS-1:0] pressed_extra,
  input  logic               load,
  input  logic               shift,
  output logic               live_a,
  output logic               serial_bit
);

  localparam int             CW      = $clog2(BUTTONS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(BUTTONS);

  logic [BUTTONS-1:0] sync1_q, sync1_d;
  logic [BUTTONS-1:0] sync2_q, sync2_d;
  logic [BUTTONS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BUTTONS-1:0] pressed;

  assign pressed    = ~sync2_q | pressed_extra;
  assign live_a     = ~sync2_q[BTN_A];
  // Once every button has been shifted out the pad reports the fill level.
  assign serial_bit = (cnt_q == CNT_MAX) ? JOY_READ_FILL : shreg_q[0];

  always_comb begin
    sync1_d = buttons_n;
    sync2_d = sync1_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = pressed;
      cnt_d   = '0;
    end else if (shift && (cnt_q != CNT_MAX)) begin
      shreg_d = {JOY_READ_FILL, shreg_q[BUTTONS-1:1]};
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/joy_multi.sv
// rtl/joy_multi.sv - NES pad interface for NUM_PORTS pads; optional turbo via JOY_TURBO_EN
module joy_multi
  import joy_pkg::*;
#(
  parameter int          NUM_PORTS = 2,
  parameter int          BUTTONS   = 8,
  parameter logic [15:0] BASE_ADDR = JOY_BASE_ADDR,
  parameter int          TURBO_DIV = 4
) (
  input  logic                           cpu_clk_in,
  input  logic                           reset_n_in,
  joy_multi_if.slave                     bus,
`ifdef JOY_TURBO_EN
  input  logic [2*NUM_PORTS-1:0]         turbo_n_in,
`endif
  input  logic [NUM_PORTS*BUTTONS-1:0]   buttons_n_in
);

  if (NUM_PORTS < 1 || NUM_PORTS > 2 || BUTTONS < 2 || BUTTONS > JOY_MAX_BUTTONS ||
      TURBO_DIV < 1) begin : g_bad_cfg
    $error("joy_multi: unsupported parameter set");
  end

  logic                         strobe_q, strobe_d;
  joy_rd_t                      rd_q, rd_d;
  logic [15:0]                  offs;
  logic                         wr_base;
  logic [NUM_PORTS-1:0]         live_a, serial, shift;
  logic [NUM_PORTS*BUTTONS-1:0] extra;
  logic                         unused_data;

  assign offs        = bus.cpu_address_in - BASE_ADDR;
  assign wr_base     = bus.cpu_write_in && (bus.cpu_address_in == BASE_ADDR);
  assign unused_data = ^bus.cpu_data_in[7:1];

  // Reads see the pre-write strobe, so a same-cycle write only matters next cycle.
  always_comb begin
    strobe_d = wr_base ? bus.cpu_data_in[0] : strobe_q;
    rd_d     = '0;
    shift    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.cpu_read_in && (offs == 16'(p))) begin
        rd_d.en      = 1'b1;
        rd_d.data[0] = strobe_q ? live_a[p] : serial[p];
        shift[p]     = !strobe_q;
      end
    end
  end

  always_ff @(posedge cpu_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      strobe_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      strobe_q <= strobe_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.cpu_data_en_out = rd_q.en;
  assign bus.cpu_data_out    = rd_q.data;

`ifdef JOY_TURBO_EN
  localparam int DW = $clog2(TURBO_DIV + 1);

  logic [2*NUM_PORTS-1:0] tsync1_q, tsync1_d;
  logic [2*NUM_PORTS-1:0] tsync2_q, tsync2_d;
  logic                   phase_q, phase_d;
  logic [DW-1:0]          div_q, div_d;
  logic                   strobe_fall;

  assign strobe_fall = wr_base && !bus.cpu_data_in[0] && strobe_q;

  always_comb begin
    tsync1_d = turbo_n_in;
    tsync2_d = tsync1_q;
    phase_d  = phase_q;
    div_d    = div_q;
    if (strobe_fall) begin
      if (div_q == DW'(TURBO_DIV - 1)) begin
        div_d   = '0;
        phase_d = !phase_q;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    extra = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      extra[p*BUTTONS + BTN_A] = ~tsync2_q[2*p]   & phase_q;
      extra[p*BUTTONS + BTN_B] = ~tsync2_q[2*p+1] & phase_q;
    end
  end

  // Phase starts at 1 so the first latch after reset reports a held turbo button.
  always_ff @(posedge cpu_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      tsync1_q <= '1;
      tsync2_q <= '1;
      phase_q  <= 1'b1;
      div_q    <= '0;
    end else begin
      tsync1_q <= tsync1_d;
      tsync2_q <= tsync2_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
    end
  end
`else
  assign extra = '0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    joy_port #(.BUTTONS(BUTTONS)) u_port (
      .clk           (cpu_clk_in),
      .rst_n         (reset_n_in),
      .buttons_n     (buttons_n_in[p*BUTTONS +: BUTTONS]),
      .pressed_extra (extra[p*BUTTONS +: BUTTONS]),
      .load          (strobe_q),
      .shift         (shift[p]),
      .live_a        (live_a[p]),
      .serial_bit    (serial[p])
    );
  end

endmodule

// File: tb/tb_joy_multi.sv
// tb/tb_joy_multi.sv - scoreboard bench for joy_multi (two 8-button pads at $4016/$4017)
module tb_joy_multi;

  localparam int NP = 2;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP*NB-1:0] buttons_n;
`ifdef JOY_TURBO_EN
  logic [2*NP-1:0] turbo_n = '1;
`endif

  always #5 clk = ~clk;

  joy_multi_if bus_if ();

  joy_multi #(
    .NUM_PORTS (NP),
    .BUTTONS   (NB),
    .BASE_ADDR (16'h4016),
    .TURBO_DIV (4)
  ) dut (
    .cpu_clk_in   (clk),
    .reset_n_in   (rst_n),
    .bus          (bus_if),
`ifdef JOY_TURBO_EN
    .turbo_n_in   (turbo_n),
`endif
    .buttons_n_in (buttons_n)
  );

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every data-valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus_if.cpu_data_en_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_en: got data %0h expected no pulse", bus_if.cpu_data_out);
      end else begin
        chk("rd_data", {24'b0, bus_if.cpu_data_out}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.cpu_write_in   = 1'b1;
    bus_if.cpu_address_in = addr;
    bus_if.cpu_data_in    = data;
    @(negedge clk);
    bus_if.cpu_write_in   = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic has_exp, input logic exp_bit);
    @(negedge clk);
    bus_if.cpu_read_in    = 1'b1;
    bus_if.cpu_address_in = addr;
    if (has_exp) exp_q.push_back({7'b0, exp_bit});
    @(negedge clk);
    bus_if.cpu_read_in    = 1'b0;
  endtask

  task automatic read_seq(input logic [15:0] addr, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) do_read(addr, 1'b1, bits[i]);
  endtask

  task automatic latch();
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
  endtask

  initial begin
    bus_if.cpu_read_in    = 1'b0;
    bus_if.cpu_write_in   = 1'b0;
    bus_if.cpu_address_in = 16'h0000;
    bus_if.cpu_data_in    = 8'h00;
    buttons_n             = '1;
    repeat (3) @(negedge clk);
    chk("reset_en", {31'b0, bus_if.cpu_data_en_out}, 32'd0);
    chk("reset_data", {24'b0, bus_if.cpu_data_out}, 32'd0);
    rst_n = 1'b1;

    // Port 0: A and Start pressed; port 1: Right pressed.
    buttons_n[7:0]  = 8'b1111_0110;
    buttons_n[15:8] = 8'h7F;
    repeat (3) @(negedge clk);
    latch();
    read_seq(16'h4016, 16'b11_0000_1001, 10);

    latch();
    read_seq(16'h4017, 16'b1000_0000, 8);
    read_seq(16'h4016, 16'b01, 2);

    // Strobe held: reads track live A with a two-cycle synchroniser lag.
    do_write(16'h4016, 8'h01);
    repeat (3) @(negedge clk);
    @(negedge clk);
    buttons_n[0] = 1'b1;
    do_read(16'h4016, 1'b1, 1'b1);
    do_read(16'h4016, 1'b1, 1'b0);
    @(negedge clk);
    buttons_n[0] = 1'b0;
    do_read(16'h4016, 1'b1, 1'b0);
    do_read(16'h4016, 1'b1, 1'b1);
    do_write(16'h4016, 8'h00);
    read_seq(16'h4016, 16'b01, 2);

    // Same-cycle write of 1 and read: read shifts out Select using the old strobe.
    @(negedge clk);
    bus_if.cpu_write_in   = 1'b1;
    bus_if.cpu_read_in    = 1'b1;
    bus_if.cpu_address_in = 16'h4016;
    bus_if.cpu_data_in    = 8'h01;
    exp_q.push_back(8'h00);
    @(negedge clk);
    bus_if.cpu_write_in   = 1'b0;
    bus_if.cpu_read_in    = 1'b0;
    do_write(16'h4016, 8'h00);
    do_read(16'h4016, 1'b1, 1'b1);

    // Frame-counter write is ignored; read outside the window stays silent.
    do_write(16'h4017, 8'h55);
    do_read(16'h4018, 1'b0, 1'b0);
    chk("oob_en", {31'b0, bus_if.cpu_data_en_out}, 32'd0);
    chk("oob_data", {24'b0, bus_if.cpu_data_out}, 32'd0);
    read_seq(16'h4016, 16'b100, 3);

    // Reset in the middle of a read sequence.
    latch();
    read_seq(16'h4016, 16'b001, 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_en", {31'b0, bus_if.cpu_data_en_out}, 32'd0);
    chk("midreset_data", {24'b0, bus_if.cpu_data_out}, 32'd0);
    rst_n = 1'b1;
    read_seq(16'h4016, 16'b1_0000_0000, 9);
    do_read(16'h4017, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
